// File: rtl/icache_param_if.sv
// Fetch-side and memory-side signals of the parametrised I-cache.
// slave: the cache. master: whatever drives fetch requests and serves memory reads.
interface icache_param_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        inval;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped instruction cache, SETS lines of WORDS 32-bit words, with a
// multi-word fill FSM and a single-cycle global invalidate.
// Optional macro ICACHE_PERF_EN: when defined, hit_count/miss_count are live
// counters; otherwise both read 0 and no counter flops exist.
module icache_param #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WORDS = 1
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_param_if.slave bus
);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned OFFW = $clog2(WORDS);
  localparam int unsigned CNTW = (OFFW > 0) ? OFFW : 1;
  localparam int unsigned TAGW = 30 - IDXW - OFFW;
  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(WORDS - 1);

  localparam logic [0:0] IDLE_I = 1'b0;
  localparam logic [0:0] LD     = 1'b1;

  logic [0:0]      r_state;
  logic [CNTW-1:0] r_wcnt;
  logic [TAGW-1:0] r_ltag;
  logic [IDXW-1:0] r_lidx;
  logic [SETS-1:0] r_valid;
  logic [TAGW-1:0] r_tag  [SETS];
  logic [31:0]     r_data [SETS][WORDS];

  logic [TAGW-1:0] w_tag;
  logic [IDXW-1:0] w_idx;
  logic [CNTW-1:0] w_word;
  logic [31:0]     w_fill_addr;
  logic            w_hit;
  logic            w_miss;
  logic            w_accept;
  logic            w_last;
  logic            w_unused_addr;

  assign w_tag         = bus.imemaddr[31 -: TAGW];
  assign w_idx         = bus.imemaddr[2+OFFW +: IDXW];
  assign w_unused_addr = ^bus.imemaddr[1:0];

  // With one word per block there is no offset field in the address.
  generate
    if (OFFW > 0) begin : g_off
      assign w_word      = bus.imemaddr[2 +: OFFW];
      assign w_fill_addr = {r_ltag, r_lidx, r_wcnt, 2'b00};
    end else begin : g_no_off
      assign w_word      = 1'b0;
      assign w_fill_addr = {r_ltag, r_lidx, 2'b00};
    end
  endgenerate

  assign w_hit    = (r_state == IDLE_I) & bus.imemREN & r_valid[w_idx] &
                    (r_tag[w_idx] == w_tag);
  assign w_miss   = (r_state == IDLE_I) & bus.imemREN & ~w_hit;
  assign w_accept = (r_state == LD) & ~bus.iwait;
  assign w_last   = w_accept & (r_wcnt == LAST_WORD);

  assign bus.ihit     = w_hit;
  assign bus.imemload = w_hit ? r_data[w_idx][w_word] : 32'd0;
  assign bus.iREN     = (r_state == LD);
  assign bus.iaddr    = (r_state == LD) ? w_fill_addr : 32'd0;

  // Fill FSM: latch the missing line, then walk its words; inval aborts a fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE_I;
      r_wcnt  <= '0;
      r_ltag  <= '0;
      r_lidx  <= '0;
    end else if (r_state == IDLE_I) begin
      if (w_miss) begin
        r_state <= LD;
        r_wcnt  <= '0;
        r_ltag  <= w_tag;
        r_lidx  <= w_idx;
      end
    end else begin
      if (bus.inval) begin
        r_state <= IDLE_I;
        r_wcnt  <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_state <= IDLE_I;
          r_wcnt  <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
    end
  end

  // Valid bits: inval wins over a completing fill so the line stays invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (bus.inval) begin
      r_valid <= '0;
    end else if (w_last) begin
      r_valid[r_lidx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_data[r_lidx][r_wcnt] <= bus.iload;
    end
    if (w_last) begin
      r_tag[r_lidx] <= r_ltag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Performance counters, wrapping at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`else
  assign bus.hit_count  = 32'd0;
  assign bus.miss_count = 32'd0;
`endif

endmodule

// File: doc/icache_param.md
# icache_param

Parametrised, direct-mapped instruction cache that sits between the fetch stage's `imemREN`/`imemaddr`/`ihit`/`imemload` interface and the memory controller's `iREN`/`iaddr`/`iwait`/`iload` port. It replaces the fixed one-word, 16-entry I-cache. It generalises block size to `WORDS` words and set count to `SETS`, and adds a multi-word fill state machine. It also adds a single-cycle global invalidate.

## Interface
- `SETS`, 16: number of lines; power of 2, range 2..256.
- `WORDS`, 1: 32-bit words per block; power of 2, range 1..8.
- Derived: `IDXW = log2(SETS)`, `OFFW = log2(WORDS)` (0 allowed), `TAGW = 30 - IDXW - OFFW`.
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  reset; asynchronous, active-low.
- `imemREN`  in  1  fetch request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] are ignored.
- `inval`  in  1  invalidate all lines.
- `ihit`  out  1  hit; `imemload` is valid in this cycle.
- `imemload`  out  32  instruction word; 0 when `ihit`=0.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address (bits [1:0]=0); 0 when `iREN`=0.
- `iwait`  in  1  memory busy; a word is accepted in a cycle where `iREN`=1 and `iwait`=0.
- `iload`  in  32  memory read data.
- `hit_count`  out  32  requests that hit; wraps at 2^32.
- `miss_count`  out  32  misses started; wraps at 2^32.

## Operation
- Address split: tag = `imemaddr[31 -: TAGW]`, idx = `imemaddr[2+OFFW +: IDXW]`, word = `imemaddr[2 +: OFFW]`.
- Line contents: `valid`, `tag[TAGW]`, `data[WORDS][32]`. Reset clears every `valid`. Data and tags are not reset.
- States: `IDLE_I`, `LD`. There is a fill word counter `wcnt` of width `max(OFFW,1)`.
- `IDLE_I`:
  - `ihit = imemREN & valid[idx] & (tag[idx]==tag)`, combinational.
  - `imemload = data[idx][word]`.
  - On `imemREN` with a miss: latch tag and idx, set `wcnt`=0, go to `LD`.
- `LD`:
  - `iREN`=1, `iaddr = {ltag, lidx, wcnt, 2'b00}`, `ihit`=0.
  - On acceptance: write `iload` into `data[lidx][wcnt]` and increment `wcnt`.
  - On acceptance of word `WORDS-1`: set `tag[lidx]`=ltag and `valid[lidx]`=1, then return to `IDLE_I`.
  - The line is marked valid only after all words are written.
- `imemREN` dropping or `imemaddr` changing during `LD` does not abort the fill. The fill completes against the latched address.
- `inval`:
  - All `valid` bits clear at the next edge.
  - In `LD`, the fill aborts: go to `IDLE_I`, and `iREN` drops the following cycle. The memory controller tolerates a dropped request.
  - `inval` takes priority over a simultaneous final-word acceptance: the line stays invalid.
  - `inval` in the same cycle as a hit does not suppress that cycle's `ihit`.
- Reset mid-fill: state returns to `IDLE_I` asynchronously, `iREN`=0 immediately, all lines are invalid.

## Timing
- Reset values: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0, `hit_count`=0, `miss_count`=0, state `IDLE_I`, `wcnt`=0.
- Hit: zero-cycle latency, combinational in the request cycle.
- Miss: 1 detect cycle, then `WORDS` accepted words, each taking 1 + (`iwait` cycles). `ihit` asserts in the cycle after the last acceptance.
  - Example: `WORDS`=2, `iwait` always 0 → miss detected at cycle 0, words accepted at cycles 1 and 2, `ihit` at cycle 3.
- `iaddr` is stable while `iwait`=1 and advances only on acceptance.
- Counters are registered and update at the edge after the event:
  - `hit_count` increments on each cycle with `ihit`=1.
  - `miss_count` increments on each `IDLE_I`→`LD` transition.

## Configuration
- `ICACHE_PERF_EN`:
  - Defined: `hit_count` and `miss_count` are live as specified above.
  - Undefined: both ports are tied to 0 and no counter flops are built; all other behaviour is identical.

## Test plan
- Reset → `ihit`=0, `iREN`=0, `iaddr`=0, counts 0. Then `imemREN`=1, `imemaddr`=0x40 → miss; `LD` issues `iaddr`=0x40, then 0x44 (`SETS`=16, `WORDS`=2).
- Fill 0x40/0x44 with 0xAAAA0001/0xAAAA0002, `iwait` held 3 cycles per word → `iaddr` holds while waiting. `ihit` at the cycle after the 0x44 accept, `imemload`=0xAAAA0001. Fetch 0x44 → immediate hit, 0xAAAA0002.
- Conflict: fetch 0x440 (same idx 8, different tag) → refill evicts; refetch 0x40 → misses again, `miss_count`=3.
- `imemREN` dropped after the first word of a fill → the second word is still fetched and the line becomes valid; a later fetch of 0x40 hits.
- `inval` pulsed on the final-word accept cycle → `iREN` drops next cycle, the line is invalid, and the next fetch of 0x40 misses.
- `nRST` asserted mid-fill → `iREN`=0 asynchronously; after release, a fetch of 0x40 misses. With `ICACHE_PERF_EN` undefined, counts read 0 throughout.
